// File: rtl/tl_vc_out_arbiter.sv
// Drains four per-class output FIFOs into one serial word stream (round-robin,
// backpressure-aware) with saturating per-channel counters. Define STRICT_PRIORITY_EN for fixed priority.

module tl_vc_cnt_lane #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  // clear beats increment; saturate instead of wrapping
  always_ff @(posedge clk or posedge reset)
    if (reset)                            cnt <= '0;
    else if (clr)                         cnt <= '0;
    else if (inc && cnt != {CNT_W{1'b1}}) cnt <= cnt + 1'b1;
endmodule

module tl_vc_out_arbiter #(
  parameter int DATA_W = 12,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic [DATA_W-1:0] data_in0,
  input  logic [DATA_W-1:0] data_in1,
  input  logic [DATA_W-1:0] data_in2,
  input  logic [DATA_W-1:0] data_in3,
  input  logic              empty0,
  input  logic              empty1,
  input  logic              empty2,
  input  logic              empty3,
  input  logic              out_full,
  output logic              pop0,
  output logic              pop1,
  output logic              pop2,
  output logic              pop3,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic [1:0]        grant,
  input  logic              req,
  input  logic [1:0]        idx,
  output logic [CNT_W-1:0]  contador,
  output logic              valid_cnt,
  output logic              idle
);
  localparam int NUM_CH = 4;
  localparam int STAGES = 2;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_ACTIVE, S_STALL} state_t;

  state_t                         state, state_nxt;
  logic [NUM_CH-1:0]              empty_v, pop_v;
  logic [NUM_CH-1:0][DATA_W-1:0]  din;
  logic [NUM_CH-1:0][CNT_W-1:0]   cnt;
  logic [STAGES:1]                vld_pipe;
  logic [1:0]                     sel, ch_q, rd_idx;
  logic                           sel_vld, pop_en, any_work, cnt_clr;
  logic [CNT_W-1:0]               cnt_hold;
`ifndef STRICT_PRIORITY_EN
  logic [1:0]                     rr_ptr, cand;
`endif

  assign empty_v  = {empty3, empty2, empty1, empty0};
  assign din      = {data_in3, data_in2, data_in1, data_in0};
  assign {pop3, pop2, pop1, pop0} = pop_v;
  assign any_work = ~&empty_v;
  assign cnt_clr  = init || (state == S_INIT);

  // Channel select: descending scan so the nearest candidate wins.
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
`ifdef STRICT_PRIORITY_EN
    for (int i = NUM_CH-1; i >= 0; i--)
      if (!empty_v[i]) begin
        sel     = i[1:0];
        sel_vld = 1'b1;
      end
`else
    cand = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      cand = rr_ptr + i[1:0];
      if (!empty_v[cand]) begin
        sel     = cand;
        sel_vld = 1'b1;
      end
    end
`endif
  end

  // init also blocks the pop so that nothing new enters the pipe while clearing
  assign pop_en = sel_vld && !out_full && !init &&
                  (state == S_ACTIVE || state == S_IDLE);
  assign pop_v  = pop_en ? (NUM_CH'(1) << sel) : '0;

  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:   state_nxt = S_IDLE;
      S_IDLE:   if (any_work) state_nxt = out_full ? S_STALL : S_ACTIVE;
      S_ACTIVE: if (out_full) state_nxt = S_STALL;
                else if (!any_work && !vld_pipe[1]) state_nxt = S_IDLE;
      S_STALL:  if (!out_full && any_work) state_nxt = S_ACTIVE;
                else if (!any_work) state_nxt = S_IDLE;
      default:  state_nxt = S_INIT;
    endcase
    if (init) state_nxt = S_INIT;
  end

  // vld_pipe[1]: word popped last cycle, data_in valid now; vld_pipe[2]: data_out valid
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_INIT;
      vld_pipe <= '0;
      ch_q     <= '0;
      data_out <= '0;
      grant    <= '0;
`ifndef STRICT_PRIORITY_EN
      rr_ptr   <= 2'd3;
`endif
    end else begin
      state    <= state_nxt;
      vld_pipe <= {vld_pipe[STAGES-1:1], pop_en};
      if (pop_en) ch_q <= sel;
      if (vld_pipe[1]) begin
        data_out <= din[ch_q];
        grant    <= ch_q;
      end
`ifndef STRICT_PRIORITY_EN
      if (init)        rr_ptr <= 2'd3;
      else if (pop_en) rr_ptr <= sel;
`endif
    end
  end

  assign valid_out = vld_pipe[STAGES];
  assign idle      = (state == S_IDLE) && !any_work && !vld_pipe[1];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
    tl_vc_cnt_lane #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (cnt_clr),
      .inc   (vld_pipe[1] && ch_q == 2'(g)),
      .cnt   (cnt[g])
    );
  end

  // Read shows the live counter during the response cycle, i.e. before that cycle's increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_cnt <= 1'b0;
      rd_idx    <= '0;
      cnt_hold  <= '0;
    end else begin
      valid_cnt <= req;
      if (req)       rd_idx   <= idx;
      if (valid_cnt) cnt_hold <= cnt[rd_idx];
    end
  end

  assign contador = valid_cnt ? cnt[rd_idx] : cnt_hold;

endmodule

// File: tb/tb_tl_vc_out_arbiter.sv
// Self-checking bench for tl_vc_out_arbiter: FIFO responders, ordered scoreboard
// built from queue contents, saturating counter model, randomized backpressure.
module tb_tl_vc_out_arbiter;
  localparam int DATA_W = 12;
  localparam int CNT_W  = 5;

  logic clk = 0, reset = 1, init = 0, out_full = 0, req = 0;
  logic [1:0] idx = '0;
  logic [3:0][DATA_W-1:0] dq = '0;
  logic [3:0] eq = '1;
  logic pop0, pop1, pop2, pop3, valid_out, valid_cnt, idle;
  logic [3:0] pops;
  logic [DATA_W-1:0] data_out;
  logic [1:0] grant;
  logic [CNT_W-1:0] contador;

  int errors = 0, checks = 0;
  typedef logic [DATA_W-1:0] wq_t [$];
  wq_t fq [4];
  typedef struct packed { logic [1:0] ch; logic [DATA_W-1:0] data; } ent_t;
  ent_t exp_q [$];
  int mptr = 3;
  int cnt_m [4] = '{default: 0};

  always #5 clk = ~clk;
  assign pops = {pop3, pop2, pop1, pop0};

  tl_vc_out_arbiter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .init(init),
    .data_in0(dq[0]), .data_in1(dq[1]), .data_in2(dq[2]), .data_in3(dq[3]),
    .empty0(eq[0]), .empty1(eq[1]), .empty2(eq[2]), .empty3(eq[3]),
    .out_full(out_full),
    .pop0(pop0), .pop1(pop1), .pop2(pop2), .pop3(pop3),
    .data_out(data_out), .valid_out(valid_out), .grant(grant),
    .req(req), .idx(idx), .contador(contador), .valid_cnt(valid_cnt), .idle(idle)
  );

  // FIFO responders: a pop presents the head word the following cycle
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (pops[k]) begin
        checks++;
        if (fq[k].size() == 0) begin
          errors++;
          $display("FAIL pop_on_empty ch%0d: got pop=1, want pop=0", k);
        end else dq[k] <= fq[k].pop_front();
      end
      eq[k] <= (fq[k].size() == 0);
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if ((pops & (pops - 4'd1)) != 4'd0) begin
        errors++;
        $display("FAIL pop_onehot: got %b, want one-hot or zero", pops);
      end
      checks++;
      if ((out_full || init) && pops != 4'd0) begin
        errors++;
        $display("FAIL pop_blocked: got %b with out_full=%0b init=%0b, want 0000", pops, out_full, init);
      end
      if (valid_out) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got ch%0d/%h, want no word", grant, data_out);
        end else begin
          ent_t e;
          e = exp_q.pop_front();
          if (grant !== e.ch || data_out !== e.data) begin
            errors++;
            $display("FAIL word: got ch%0d/%h, want ch%0d/%h", grant, data_out, e.ch, e.data);
          end
        end
        if (cnt_m[grant] < 31) cnt_m[grant]++;
      end
    end
  end

  // Expected delivery order from the current FIFO contents and arbitration pointer.
  function automatic void build_exp();
    int n [4];
    int p, c;
    ent_t e;
    n = '{default: 0};
    p = mptr;
    while (1) begin
      c = -1;
`ifdef STRICT_PRIORITY_EN
      for (int i = 0; i < 4; i++) if (c < 0 && n[i] < fq[i].size()) c = i;
`else
      for (int i = 1; i <= 4; i++) if (c < 0 && n[(p+i)%4] < fq[(p+i)%4].size()) c = (p+i)%4;
`endif
      if (c < 0) break;
      e.ch = c[1:0];
      e.data = fq[c][n[c]];
      exp_q.push_back(e);
      n[c]++;
      p = c;
    end
    mptr = p;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_words(input int k, input int n);
    logic [7:0] r;
    for (int j = 0; j < n; j++) begin
      r = 8'($urandom);
      fq[k].push_back({k[1:0], j[1:0], r});
    end
  endtask

  task automatic wait_valid(input int maxc);
    for (int t = 0; t < maxc && valid_out !== 1'b1; t++) tick();
  endtask

  task automatic wait_drain(input int maxc);
    int t;
    for (t = 0; t < maxc; t++) begin
      if (exp_q.size() == 0 && idle === 1'b1) break;
      tick();
    end
    checks++;
    if (t == maxc) begin
      errors++;
      $display("FAIL drain_timeout: got %0d words pending idle=%0b, want 0 pending idle=1", exp_q.size(), idle);
    end
  endtask

  task automatic read_cnt(input int k, input int expv);
    idx = 2'(k); req = 1; tick(); req = 0;
    checks++;
    if (valid_cnt !== 1'b1 || contador !== CNT_W'(expv)) begin
      errors++;
      $display("FAIL cnt_read idx%0d: got valid=%0b cnt=%0d, want valid=1 cnt=%0d", k, valid_cnt, contador, expv);
    end
    tick();
    checks++;
    if (valid_cnt !== 1'b0 || contador !== CNT_W'(expv)) begin
      errors++;
      $display("FAIL cnt_hold idx%0d: got valid=%0b cnt=%0d, want valid=0 cnt=%0d", k, valid_cnt, contador, expv);
    end
  endtask

  task automatic test_reset();
    fq[0].push_back(12'h0A1);
    fq[2].push_back(12'h2B2);
    build_exp();
    repeat (3) tick();
    checks++;
    if (pops !== 4'b0 || data_out !== '0 || valid_out !== 1'b0 || grant !== 2'd0) begin
      errors++;
      $display("FAIL reset_out: got pops=%b data=%h valid=%0b grant=%0d, want all 0", pops, data_out, valid_out, grant);
    end
    checks++;
    if (contador !== '0 || valid_cnt !== 1'b0 || idle !== 1'b0) begin
      errors++;
      $display("FAIL reset_cnt: got cnt=%0d valid_cnt=%0b idle=%0b, want 0 0 0", contador, valid_cnt, idle);
    end
    reset = 0;
    checks++;
    if (idle !== 1'b0 || pops !== 4'b0) begin
      errors++;
      $display("FAIL init_cycle: got idle=%0b pops=%b, want 0 0000", idle, pops);
    end
  endtask

  task automatic test_two_channels();
    tick();
    checks++;
    if (pops !== 4'b0001) begin errors++; $display("FAIL first_pop: got %b, want 0001", pops); end
    tick();
    checks++;
    if (pops !== 4'b0100) begin errors++; $display("FAIL second_pop: got %b, want 0100", pops); end
    tick();
    checks++;
    if (valid_out !== 1'b1 || grant !== 2'd0 || data_out !== 12'h0A1) begin
      errors++;
      $display("FAIL first_word: got v=%0b ch%0d/%h, want v=1 ch0/0a1", valid_out, grant, data_out);
    end
    tick();
    checks++;
    if (valid_out !== 1'b1 || grant !== 2'd2 || data_out !== 12'h2B2) begin
      errors++;
      $display("FAIL second_word: got v=%0b ch%0d/%h, want v=1 ch2/2b2", valid_out, grant, data_out);
    end
    repeat (2) tick();
    checks++;
    if (idle !== 1'b1 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL idle_after: got idle=%0b valid=%0b, want 1 0", idle, valid_out);
    end
  endtask

  task automatic do_init();
    tick(); init = 1; tick(); init = 0;
    mptr = 3;
    cnt_m = '{default: 0};
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) push_words(k, 3);
    build_exp();
    wait_valid(20);
    for (int i = 0; i < 12; i++) begin
      checks++;
`ifdef STRICT_PRIORITY_EN
      if (valid_out !== 1'b1 || grant !== 2'(i / 3)) begin
`else
      if (valid_out !== 1'b1 || grant !== 2'(i % 4)) begin
`endif
        errors++;
        $display("FAIL btb_seq[%0d]: got v=%0b ch%0d, want continuous grants", i, valid_out, grant);
      end
      tick();
    end
    wait_drain(30);
    for (int k = 0; k < 4; k++) read_cnt(k, 3);
  endtask

  task automatic test_backpressure();
    bit got1;
    int t;
    fq[1].push_back(12'h1A5);
    fq[2].push_back(12'h2C6);
    fq[2].push_back(12'h2D7);
    build_exp();
    for (t = 0; t < 20; t++) begin tick(); if (pops[1]) break; end
    checks++;
    if (pops !== 4'b0010) begin errors++; $display("FAIL bp_pop1: got %b, want 0010", pops); end
    tick();
    out_full = 1;
    got1 = 0;
    repeat (5) begin
      tick();
      checks++;
      if (pops !== 4'b0) begin errors++; $display("FAIL bp_nopop: got %b, want 0000", pops); end
      if (valid_out === 1'b1 && grant === 2'd1 && data_out === 12'h1A5) got1 = 1;
    end
    checks++;
    if (!got1) begin errors++; $display("FAIL bp_skid: got no ch1 word under out_full, want ch1/1a5"); end
    out_full = 0;
    wait_valid(20);
    checks++;
    if (valid_out !== 1'b1 || grant !== 2'd2) begin
      errors++;
      $display("FAIL bp_resume: got v=%0b ch%0d, want v=1 ch2", valid_out, grant);
    end
    wait_drain(30);
  endtask

  task automatic test_saturation();
    push_words(3, 40);
    build_exp();
    wait_drain(200);
    read_cnt(3, 31);
  endtask

  task automatic test_init_mid_stream();
    int np;
    ent_t k0, k1;
    for (int k = 0; k < 4; k++) push_words(k, 2);
    build_exp();
    np = 0;
    for (int t = 0; t < 40 && np < 3; t++) begin tick(); if (pops != 4'b0) np++; end
    checks++;
    if (np != 3) begin errors++; $display("FAIL init_setup: got %0d pops, want 3", np); end
    tick();
    init = 1;
    // the two words popped before init are still in the pipe
    k0 = exp_q[0];
    k1 = exp_q[1];
    exp_q.delete();
    exp_q.push_back(k0);
    exp_q.push_back(k1);
    mptr = 3;
    build_exp();
    tick();
    init = 0;
    checks++;
    if (valid_out !== 1'b1 || grant !== k1.ch || data_out !== k1.data) begin
      errors++;
      $display("FAIL init_inflight: got v=%0b ch%0d/%h, want v=1 ch%0d/%h", valid_out, grant, data_out, k1.ch, k1.data);
    end
    idx = k1.ch; req = 1; tick(); req = 0;
    cnt_m = '{default: 0};
    checks++;
    if (valid_cnt !== 1'b1 || contador !== '0) begin
      errors++;
      $display("FAIL init_cnt: got valid=%0b cnt=%0d, want valid=1 cnt=0", valid_cnt, contador);
    end
    wait_valid(20);
    checks++;
    if (valid_out !== 1'b1 || grant !== 2'd0) begin
      errors++;
      $display("FAIL init_next_grant: got v=%0b ch%0d, want v=1 ch0", valid_out, grant);
    end
    wait_drain(40);
    for (int k = 0; k < 4; k++) read_cnt(k, cnt_m[k]);
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 4; k++) push_words(k, $urandom_range(0, 6));
      build_exp();
      for (int t = 0; t < 400; t++) begin
        if (exp_q.size() == 0 && idle === 1'b1) break;
        out_full = ($urandom_range(0, 2) == 0);
        tick();
      end
      out_full = 0;
      wait_drain(40);
      for (int k = 0; k < 4; k++) read_cnt(k, cnt_m[k]);
    end
  endtask

  initial begin
    test_reset();
    test_two_channels();
    do_init();
    test_back_to_back();
    test_backpressure();
    test_saturation();
    test_init_mid_stream();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got simulation still running, want completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end
endmodule
